// File: rtl/byter_sequencer.sv
// Fetch/execute controller for the byter 8-bit CPU: owns pc/ir, runs the
// imem and data-RAM handshakes, and issues one exec_en commit strobe per instruction.
module byter_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  output logic             halted,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_data,
  output logic [7:0]       ir,
  input  logic             dec_loadPC,
  input  logic             dec_incPC,
  input  logic             dec_csPCadd,
  input  logic             dec_csRam,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [7:0]       pc_offset,
  output logic             ram_req,
  input  logic             ram_ack,
  output logic             exec_en,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t state;
  logic   step_flag;
  logic   done;

  // All handshake outputs are decodes of the state register, so reset clears them at once.
  assign done      = (state == S_EXEC) && (!dec_csRam || ram_ack);
  assign exec_en   = done;
  assign ram_req   = (state == S_EXEC) && dec_csRam;
  assign imem_req  = (state == S_FETCH);
  assign halted    = (state == S_HALT);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HALT;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      retired   <= '0;
      step_flag <= 1'b0;
    end else begin
      case (state)
        S_HALT: begin
          if (step) step_flag <= 1'b1;
          if (run || step) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (done) begin
            // Fixed priority: absolute jump, then relative add, then increment.
            if (dec_loadPC)       pc <= jump_target;
            else if (dec_csPCadd) pc <= pc + PC_W'($signed(pc_offset));
            else if (dec_incPC)   pc <= pc + PC_W'(1);
            retired   <= retired + CNT_W'(1);
            step_flag <= 1'b0;
            state     <= (step_flag || !run) ? S_HALT : S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_byter_sequencer.sv
// Self-checking bench for byter_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_byter_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, step;
  logic        halted;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_data;
  logic [7:0]  ir;
  logic        dec_loadPC, dec_incPC, dec_csPCadd, dec_csRam;
  logic [7:0]  jump_target;
  logic [7:0]  pc_offset;
  logic        ram_req, ram_ack;
  logic        exec_en;
  logic [7:0]  pc;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;
  int mpc   = 0;
  int mret  = 0;
  bit stepping = 1'b0;

  byter_sequencer #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .ir(ir),
    .dec_loadPC(dec_loadPC), .dec_incPC(dec_incPC),
    .dec_csPCadd(dec_csPCadd), .dec_csRam(dec_csRam),
    .jump_target(jump_target), .pc_offset(pc_offset),
    .ram_req(ram_req), .ram_ack(ram_ack), .exec_en(exec_en),
    .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction through fetch and execute, then checks the committed result.
  task automatic run_instr(input int iw, input bit cs, input int rw,
                           input bit ld, input bit ad, input bit inc,
                           input logic [7:0] tgt, input logic [7:0] off,
                           input logic [7:0] data, input int drop_at, input bit pstep);
    int n;
    int so;
    bit eh;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < iw; i++) begin
      chk("fetch_addr", 32'(imem_addr), 32'(mpc));
      chk("fetch_noexec", 32'(exec_en), 32'd0);
      imem_ack    = 1'b0;
      ram_ack     = 1'($urandom);
      dec_csRam   = 1'($urandom);
      dec_loadPC  = 1'($urandom);
      dec_incPC   = 1'($urandom);
      dec_csPCadd = 1'($urandom);
      @(negedge clk);
      chk("fetch_hold", 32'(imem_req), 32'd1);
    end
    chk("fetch_addr", 32'(imem_addr), 32'(mpc));
    imem_ack  = 1'b1;
    imem_data = data;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 8'($urandom);
    chk("ir", 32'(ir), 32'(data));
    chk("exec_noreq", 32'(imem_req), 32'd0);
    dec_loadPC  = ld;
    dec_csPCadd = ad;
    dec_incPC   = inc;
    dec_csRam   = cs;
    jump_target = tgt;
    pc_offset   = off;
    step        = pstep;
    if (cs) begin
      for (int i = 0; i < rw; i++) begin
        ram_ack  = 1'b0;
        imem_ack = 1'($urandom);
        if (i == drop_at) run = 1'b0;
        #1;
        chk("ram_wait_req", 32'(ram_req), 32'd1);
        chk("ram_wait_noexec", 32'(exec_en), 32'd0);
        @(negedge clk);
        step = 1'b0;
      end
    end
    ram_ack = cs ? 1'b1 : 1'($urandom);
    #1;
    chk("exec_pulse", 32'(exec_en), 32'd1);
    chk("exec_ram_req", 32'(ram_req), 32'(cs));
    eh = stepping || !run;
    so = (off >= 8'h80) ? int'(off) - 256 : int'(off);
    if (ld)       mpc = int'(tgt);
    else if (ad)  mpc = (mpc + so + 256) % 256;
    else if (inc) mpc = (mpc + 1) % 256;
    mret = (mret + 1) % 65536;
    @(negedge clk);
    step        = 1'b0;
    ram_ack     = 1'b0;
    imem_ack    = 1'b0;
    dec_loadPC  = 1'b0;
    dec_csPCadd = 1'b0;
    dec_incPC   = 1'b0;
    dec_csRam   = 1'b0;
    chk("pc", 32'(pc), 32'(mpc));
    chk("retired", 32'(retired), 32'(mret));
    chk("halted_after", 32'(halted), 32'(eh));
    chk("exec_single", 32'(exec_en), 32'd0);
    stepping = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    imem_ack = 1'b0; imem_data = 8'h00; ram_ack = 1'b0;
    dec_loadPC = 1'b0; dec_incPC = 1'b0; dec_csPCadd = 1'b0; dec_csRam = 1'b0;
    jump_target = 8'h00; pc_offset = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_exec_en", 32'(exec_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_halted", 32'(halted), 32'd1);

    // Zero-wait NOP stream.
    run = 1'b1;
    repeat (3) run_instr(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("nop_retired3", 32'(retired), 32'd3);

    // Jumps and pc wrap.
    run_instr(0, 0, 0, 1, 0, 0, 8'hF0, 8'h00, 8'h40, -1, 0);
    run_instr(1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    run_instr(0, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 8'h40, -1, 0);
    run_instr(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("wrap_pc", 32'(pc), 32'd0);

    // Relative adds with incPC also asserted.
    run_instr(0, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h40, -1, 0);
    run_instr(0, 0, 0, 0, 1, 1, 8'h00, 8'hFC, 8'h60, -1, 0);
    chk("pcadd_neg", 32'(pc), 32'h0C);
    run_instr(0, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h40, -1, 0);
    run_instr(0, 0, 0, 0, 1, 1, 8'h00, 8'h05, 8'h60, -1, 0);
    chk("pcadd_pos", 32'(pc), 32'h15);

    // Store with a 3-cycle RAM wait.
    run_instr(0, 1, 3, 0, 0, 1, 8'h00, 8'h00, 8'h80, -1, 0);

    // Halt, single-step twice, then drop run during a RAM wait.
    run = 1'b0;
    run_instr(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("halt_idle_req", 32'(imem_req), 32'd0);
    end
    chk("halt_idle", 32'(halted), 32'd1);
    repeat (2) begin
      step = 1'b1; stepping = 1'b1;
      @(negedge clk);
      step = 1'b0;
      run_instr(1, 1, 1, 0, 0, 1, 8'h00, 8'h00, 8'h81, -1, 0);
    end
    run = 1'b1;
    run_instr(0, 1, 3, 0, 0, 1, 8'h00, 8'h00, 8'h82, 1, 0);

    // Random instruction stream with wait states, ack noise and ignored steps.
    run = 1'b1;
    for (int k = 0; k < 40; k++)
      run_instr(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), -1, 1'($urandom));

    // Reset during a fetch with ack pending.
    begin
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rstf_req", 32'(imem_req), 32'd1);
      imem_ack = 1'b1; imem_data = 8'hAB;
      #2 rst_n = 1'b0;
      #1;
      chk("rstf_imem_req", 32'(imem_req), 32'd0);
      chk("rstf_pc", 32'(pc), 32'd0);
      chk("rstf_ir", 32'(ir), 32'd0);
      chk("rstf_halted", 32'(halted), 32'd1);
      chk("rstf_exec_en", 32'(exec_en), 32'd0);
      chk("rstf_retired", 32'(retired), 32'd0);
      @(negedge clk);
      chk("rstf_ir_hold", 32'(ir), 32'd0);
      chk("rstf_noexec", 32'(exec_en), 32'd0);
      imem_ack = 1'b0;
      rst_n = 1'b1;
      mpc = 0; mret = 0; stepping = 1'b0;
      run_instr(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
